// File: rtl/log_capture_ctrl.sv
// GPIO-commanded capture controller that sequences one full pass of writes into the log BRAMs.
// Optional macro LOG_TRIGGER_EN adds an ARMED state that waits for i_trigger before capturing.
module log_capture_ctrl #(
  parameter int GPIO_LEN      = 32,
  parameter int OPCODE_LEN    = 16,
  parameter int DATA_LEN      = 15,
  parameter int RAM_ADDR_NBIT = 5
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [GPIO_LEN-1:0]      i_gpio_in,
  input  logic                     i_trigger,
  output logic                     o_enable_encoder,
  output logic                     o_write_enable,
  output logic [RAM_ADDR_NBIT-1:0] o_write_address,
  output logic [RAM_ADDR_NBIT-1:0] o_read_address,
  output logic                     o_done,
  output logic [1:0]               o_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [OPCODE_LEN-1:0]    OP_START       = OPCODE_LEN'(1);
  localparam logic [OPCODE_LEN-1:0]    OP_ABORT       = OPCODE_LEN'(2);
  localparam logic [OPCODE_LEN-1:0]    OP_SET_RD_ADDR = OPCODE_LEN'(3);
  localparam logic [RAM_ADDR_NBIT-1:0] LAST_ADDR      = {RAM_ADDR_NBIT{1'b1}};

  state_t                  state;
  logic                    enable_q;
  logic                    cmd_ready;
  logic                    gpio_enable;
  logic [OPCODE_LEN-1:0]   opcode;
  logic [DATA_LEN-1:0]     data;
  logic                    cmd_valid;
  logic                    data_unused;

  assign gpio_enable = i_gpio_in[GPIO_LEN-1];
  assign opcode      = i_gpio_in[GPIO_LEN-2 -: OPCODE_LEN];
  assign data        = i_gpio_in[DATA_LEN-1:0];
  assign data_unused = ^data[DATA_LEN-1:RAM_ADDR_NBIT];
  assign o_state     = state;

  // cmd_ready blocks an enable that was already high at reset until it has been seen low
  assign cmd_valid = gpio_enable & ~enable_q & cmd_ready;

`ifndef LOG_TRIGGER_EN
  logic trigger_unused;
  assign trigger_unused = i_trigger;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state            <= ST_IDLE;
      o_write_address  <= '0;
      o_read_address   <= '0;
      o_done           <= 1'b0;
      o_enable_encoder <= 1'b0;
      o_write_enable   <= 1'b0;
      enable_q         <= 1'b0;
      cmd_ready        <= ~gpio_enable;
    end else begin
      enable_q <= gpio_enable;
      if (!gpio_enable) cmd_ready <= 1'b1;

      if (cmd_valid && opcode == OP_SET_RD_ADDR)
        o_read_address <= data[RAM_ADDR_NBIT-1:0];

      if (cmd_valid && opcode == OP_ABORT) begin
        state            <= ST_IDLE;
        o_write_address  <= '0;
        o_done           <= 1'b0;
        o_enable_encoder <= 1'b0;
        o_write_enable   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (cmd_valid && opcode == OP_START) begin
`ifdef LOG_TRIGGER_EN
              state          <= ST_ARMED;
              o_write_enable <= 1'b0;
`else
              state          <= ST_CAPTURE;
              o_write_enable <= 1'b1;
`endif
              o_enable_encoder <= 1'b1;
              o_write_address  <= '0;
              o_done           <= 1'b0;
            end
          end
          ST_ARMED: begin
`ifdef LOG_TRIGGER_EN
            if (i_trigger) begin
              state            <= ST_CAPTURE;
              o_write_address  <= '0;
              o_enable_encoder <= 1'b1;
              o_write_enable   <= 1'b1;
            end
`else
            state            <= ST_IDLE;
            o_enable_encoder <= 1'b0;
            o_write_enable   <= 1'b0;
`endif
          end
          ST_CAPTURE: begin
            if (o_write_address == LAST_ADDR) begin
              state            <= ST_DONE;
              o_write_address  <= '0;
              o_done           <= 1'b1;
              o_enable_encoder <= 1'b0;
              o_write_enable   <= 1'b0;
            end else begin
              o_write_address <= o_write_address + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
